// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz round sequencer: state encoding,
// player count and the Player_Number encoding (0 = no winner).
package quiz_pkg;

  localparam int NPLAYER = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam logic [3:0] PNUM_NONE       = 4'd0;
  localparam logic [1:0] LAST_WINNER_RST = 2'd3;

  function automatic logic [3:0] idx_to_pnum(input logic [1:0] idx);
    return {2'b00, idx} + 4'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational 4-way round-robin arbiter; the search starts one past the
// previous winner so every player gets a fair turn at first priority.
module rr_arbiter
  import quiz_pkg::*;
(
  input  logic [3:0] i_request,
  input  logic [1:0] i_last_winner,
  output logic [3:0] o_grant,
  output logic [1:0] o_index
);

  logic [1:0] w_idx;
  logic       w_found;

  // Walk the four positions after the last winner, first request wins
  always_comb begin
    o_grant = 4'b0000;
    o_index = 2'd0;
    w_idx   = 2'd0;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = i_last_winner + 2'(k);
      if (!w_found && i_request[w_idx]) begin
        w_found          = 1'b1;
        o_grant[w_idx]   = 1'b1;
        o_index          = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the four-player quiz responder: arms, arbitrates,
// collects the verdict and keeps saturating scores. Optional macro:
// FALSE_START_EN (presses while IDLE lock that player out of the next round).
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int SCORE_W = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic                     Abort,
  input  logic [3:0]               Key_In,
  input  logic                     Judge_OK,
  input  logic                     Judge_Fail,
  input  logic                     Timer_Done,
  input  logic                     Score_Clr,
  output logic [3:0]               Grant,
  output logic [3:0]               Player_Number,
  output logic                     Timer_Start,
  output logic                     Buzzer_Req,
  output logic                     Round_Done,
  output logic [4*SCORE_W-1:0]     Score_Out,
  output logic [1:0]               State_Out
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t             r_state, w_next;
  logic [3:0]         r_key_q, w_edge, w_cand, r_lockout;
  logic [3:0]         w_arb_grant, r_grant, r_pnum;
  logic [1:0]         w_arb_idx, r_last_winner;
  logic               w_grant_ev, w_score_inc, w_to_result, w_abort_end, w_start_ev;
  logic               r_timer_start, r_buzzer, r_round_done;
  logic [SCORE_W-1:0] r_score [NPLAYER];

  assign w_edge = Key_In & ~r_key_q;
  assign w_cand = w_edge & ~r_lockout;

  rr_arbiter u_arb (
    .i_request     (w_cand),
    .i_last_winner (r_last_winner),
    .o_grant       (w_arb_grant),
    .o_index       (w_arb_idx)
  );

  // Previous-cycle key copy for rising-edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_key_q <= 4'b0000;
    else     r_key_q <= Key_In;
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and event decode; a simultaneous Fail overrides OK
  always_comb begin
    w_next      = r_state;
    w_grant_ev  = 1'b0;
    w_score_inc = 1'b0;
    w_to_result = 1'b0;
    w_abort_end = 1'b0;
    w_start_ev  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_next     = ST_ARMED;
          w_start_ev = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (Abort) begin
          w_next      = ST_IDLE;
          w_abort_end = 1'b1;
        end else if (|w_cand) begin
          w_next     = ST_LOCKED;
          w_grant_ev = 1'b1;
        end else begin
          w_next = ST_ARMED;
        end
      end
      ST_LOCKED: begin
        if (Abort) begin
          w_next      = ST_IDLE;
          w_abort_end = 1'b1;
        end else if (Judge_Fail) begin
          w_next      = ST_RESULT;
          w_to_result = 1'b1;
        end else if (Judge_OK) begin
          w_next      = ST_RESULT;
          w_to_result = 1'b1;
          w_score_inc = 1'b1;
        end else if (Timer_Done) begin
          w_next      = ST_RESULT;
          w_to_result = 1'b1;
        end else begin
          w_next = ST_LOCKED;
        end
      end
      ST_RESULT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Registered grant, player number and one-cycle pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_grant       <= 4'b0000;
      r_pnum        <= PNUM_NONE;
      r_last_winner <= LAST_WINNER_RST;
      r_timer_start <= 1'b0;
      r_buzzer      <= 1'b0;
      r_round_done  <= 1'b0;
    end else begin
      r_timer_start <= w_grant_ev;
      r_buzzer      <= w_grant_ev;
      r_round_done  <= w_to_result;
      if (w_grant_ev) begin
        r_grant       <= w_arb_grant;
        r_last_winner <= w_arb_idx;
      end else if (w_next != ST_LOCKED) begin
        r_grant <= 4'b0000;
      end
      // The winner stays on the display until the next round is started
      if (w_grant_ev)      r_pnum <= idx_to_pnum(w_arb_idx);
      else if (w_start_ev) r_pnum <= PNUM_NONE;
    end
  end

  // Per-player saturating scores; clear is only honoured while idle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NPLAYER; i++) r_score[i] <= '0;
    end else if (r_state == ST_IDLE && Score_Clr) begin
      for (int i = 0; i < NPLAYER; i++) r_score[i] <= '0;
    end else if (w_score_inc && r_score[r_last_winner] != SCORE_MAX) begin
      r_score[r_last_winner] <= r_score[r_last_winner] + SCORE_W'(1);
    end
  end

`ifdef FALSE_START_EN
  // False-start mask: built up while idle, dropped when a round ends
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                   r_lockout <= 4'b0000;
    else if (w_abort_end || r_state == ST_RESULT) r_lockout <= 4'b0000;
    else if (r_state == ST_IDLE)               r_lockout <= r_lockout | w_edge;
  end
`else
  // Without false-start detection nobody is ever locked out
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_lockout <= 4'b0000;
    else     r_lockout <= 4'b0000;
  end
`endif

  // Pack scores with player 1 in the least significant field
  always_comb begin
    Score_Out = '0;
    for (int i = 0; i < NPLAYER; i++) Score_Out[i*SCORE_W +: SCORE_W] = r_score[i];
  end

  assign Grant         = r_grant;
  assign Player_Number = r_pnum;
  assign Timer_Start   = r_timer_start;
  assign Buzzer_Req    = r_buzzer;
  assign Round_Done    = r_round_done;
  assign State_Out     = r_state;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl: grants and round results are
// predicted when stimulus is driven and checked when the DUT pulses.
module tb_quiz_round_ctrl;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        Start = 1'b0, Abort = 1'b0, Judge_OK = 1'b0, Judge_Fail = 1'b0;
  logic        Timer_Done = 1'b0, Score_Clr = 1'b0;
  logic [3:0]  Key_In = 4'b0000;
  logic [3:0]  Grant, Player_Number;
  logic        Timer_Start, Buzzer_Req, Round_Done;
  logic [15:0] Score_Out;
  logic [1:0]  State_Out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] pnum;
  } grant_exp_t;

  grant_exp_t  q_grant[$];
  logic [15:0] q_score[$];

  logic [3:0]  m_score [4];
  logic [1:0]  m_last;
  logic [3:0]  m_lock;
  logic [3:0]  m_prev;

  quiz_round_ctrl #(.SCORE_W(4)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort), .Key_In(Key_In),
    .Judge_OK(Judge_OK), .Judge_Fail(Judge_Fail), .Timer_Done(Timer_Done),
    .Score_Clr(Score_Clr), .Grant(Grant), .Player_Number(Player_Number),
    .Timer_Start(Timer_Start), .Buzzer_Req(Buzzer_Req), .Round_Done(Round_Done),
    .Score_Out(Score_Out), .State_Out(State_Out)
  );

  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] model_pack();
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = m_score[i];
    return v;
  endfunction

  function automatic logic [1:0] model_arb(input logic [3:0] req, input logic [1:0] last);
    int j;
    for (int k = 1; k <= 4; k++) begin
      j = (int'(last) + k) % 4;
      if (req[j]) return 2'(j);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_score[i] = 4'd0;
    m_last = 2'd3;
    m_lock = 4'b0000;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops expectations when the DUT reports a grant or a finished round
  always @(negedge CLK) begin
    if (!RST) begin
      if (Buzzer_Req) begin
        if (q_grant.size() == 0) begin
          check_value("unexpected_grant", {28'd0, Grant}, 32'd0);
        end else begin
          grant_exp_t e;
          e = q_grant.pop_front();
          check_value("grant", {28'd0, Grant}, {28'd0, e.grant});
          check_value("player_number", {28'd0, Player_Number}, {28'd0, e.pnum});
          check_value("timer_start", {31'd0, Timer_Start}, 32'd1);
        end
      end
      if (Round_Done) begin
        if (q_score.size() == 0) begin
          check_value("unexpected_round_done", {31'd0, Round_Done}, 32'd0);
        end else begin
          check_value("score_out", {16'd0, Score_Out}, {16'd0, q_score.pop_front()});
          check_value("grant_in_result", {28'd0, Grant}, 32'd0);
        end
      end
    end
  end

  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check_value("start_state", {30'd0, State_Out}, 32'd1);
    check_value("start_pnum_clear", {28'd0, Player_Number}, 32'd0);
  endtask

  task automatic set_keys(input logic [3:0] keys);
    Key_In = keys;
    m_prev = keys;
    tick();
  endtask

  // Key change while idle: under false-start detection it locks the player out
  task automatic idle_keys(input logic [3:0] keys);
`ifdef FALSE_START_EN
    m_lock = m_lock | (keys & ~m_prev);
`endif
    set_keys(keys);
  endtask

  task automatic press(input logic [3:0] keys);
    logic [3:0] cand;
    logic [1:0] idx;
    cand = keys & ~m_prev & ~m_lock;
    if (cand != 4'b0000) begin
      idx = model_arb(cand, m_last);
      m_last = idx;
      q_grant.push_back('{grant: 4'b0001 << idx, pnum: {2'b00, idx} + 4'd1});
    end
    set_keys(keys);
    if (cand != 4'b0000) check_value("locked_state", {30'd0, State_Out}, 32'd2);
    else                 check_value("armed_hold", {30'd0, State_Out}, 32'd1);
  endtask

  task automatic verdict(input logic ok, input logic fail, input logic td);
    if (!fail && ok && m_score[m_last] != 4'hF) m_score[m_last] = m_score[m_last] + 4'd1;
    q_score.push_back(model_pack());
    Judge_OK = ok; Judge_Fail = fail; Timer_Done = td;
    tick();
    Judge_OK = 1'b0; Judge_Fail = 1'b0; Timer_Done = 1'b0;
    check_value("result_state", {30'd0, State_Out}, 32'd3);
    check_value("pnum_in_result", {28'd0, Player_Number}, {28'd0, {2'b00, m_last} + 4'd1});
    check_value("timer_start_low", {31'd0, Timer_Start}, 32'd0);
    tick();
    m_lock = 4'b0000;
    check_value("idle_after_result", {30'd0, State_Out}, 32'd0);
    check_value("round_done_one_cycle", {31'd0, Round_Done}, 32'd0);
    check_value("pnum_held_idle", {28'd0, Player_Number}, {28'd0, {2'b00, m_last} + 4'd1});
  endtask

  task automatic round(input logic [3:0] keys, input logic ok, input logic fail, input logic td);
    do_start();
    press(keys);
    set_keys(4'b0000);
    verdict(ok, fail, td);
  endtask

  initial begin
    model_reset();
    m_prev = 4'b0000;
    repeat (3) tick();
    check_value("rst_state", {30'd0, State_Out}, 32'd0);
    check_value("rst_grant", {28'd0, Grant}, 32'd0);
    check_value("rst_pnum", {28'd0, Player_Number}, 32'd0);
    check_value("rst_score", {16'd0, Score_Out}, 32'd0);
    check_value("rst_pulses", {29'd0, Timer_Start, Buzzer_Req, Round_Done}, 32'd0);
    RST = 1'b0;
    tick();

    // Basic round and round-robin rotation after player 2 wins
    round(4'b0010, 1'b1, 1'b0, 1'b0);
    round(4'b1111, 1'b1, 1'b0, 1'b1);
    round(4'b1111, 1'b0, 1'b0, 1'b1);
    round(4'b1111, 1'b1, 1'b1, 1'b0);

    // Player 1 saturation
    for (int r = 0; r < 16; r++) round(4'b0001, 1'b1, 1'b0, 1'b0);
    check_value("saturated_p1", {28'd0, Score_Out[3:0]}, 32'd15);

    // Verdicts outside LOCKED are ignored
    Judge_OK = 1'b1; Timer_Done = 1'b1;
    tick();
    Judge_OK = 1'b0; Timer_Done = 1'b0;
    check_value("judge_in_idle_state", {30'd0, State_Out}, 32'd0);
    check_value("judge_in_idle_score", {16'd0, Score_Out}, {16'd0, model_pack()});
    do_start();
    Judge_OK = 1'b1;
    tick();
    Judge_OK = 1'b0;
    check_value("judge_in_armed", {30'd0, State_Out}, 32'd1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check_value("start_in_armed", {30'd0, State_Out}, 32'd1);

    // Abort in LOCKED and in ARMED
    press(4'b0100);
    set_keys(4'b0000);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    m_lock = 4'b0000;
    check_value("abort_locked_state", {30'd0, State_Out}, 32'd0);
    check_value("abort_locked_grant", {28'd0, Grant}, 32'd0);
    check_value("abort_score", {16'd0, Score_Out}, {16'd0, model_pack()});
    do_start();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check_value("abort_armed_state", {30'd0, State_Out}, 32'd0);

    // Score clear ignored in LOCKED, honoured in IDLE
    do_start();
    press(4'b1000);
    Score_Clr = 1'b1;
    tick();
    Score_Clr = 1'b0;
    check_value("clr_in_locked", {16'd0, Score_Out}, {16'd0, model_pack()});
    set_keys(4'b0000);
    verdict(1'b0, 1'b1, 1'b0);
    Score_Clr = 1'b1;
    tick();
    Score_Clr = 1'b0;
    for (int i = 0; i < 4; i++) m_score[i] = 4'd0;
    check_value("clr_in_idle", {16'd0, Score_Out}, 32'd0);

    // Press while idle: locks out player 3 only with false-start detection
    idle_keys(4'b0100);
    idle_keys(4'b0000);
    do_start();
    press(4'b0100);
`ifdef FALSE_START_EN
    set_keys(4'b0000);
    press(4'b0001);
`endif
    set_keys(4'b0000);
    verdict(1'b0, 1'b1, 1'b0);
    round(4'b0100, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a round
    do_start();
    press(4'b0010);
    set_keys(4'b0000);
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_value("midrst_state", {30'd0, State_Out}, 32'd0);
    check_value("midrst_grant", {28'd0, Grant}, 32'd0);
    check_value("midrst_pnum", {28'd0, Player_Number}, 32'd0);
    check_value("midrst_score", {16'd0, Score_Out}, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    round(4'b1111, 1'b1, 1'b0, 1'b0);

    repeat (2) tick();
    check_value("grant_queue_empty", q_grant.size(), 32'd0);
    check_value("score_queue_empty", q_score.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
